perf_counter_ctrl: RTL and testbench
====================================

PERF_COUNTER_CTRL -- requirements
Module: perf_counter_ctrl

Interface
REQ-001 Parameter CTR_WIDTH, default 32, counter and MMIO data width.
REQ-002 Parameter MMIO_LIMIT, default 32, first byte address outside the counter window.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 instr_req, instr_resp  in  1 each  I-side access start / completion strobes.
REQ-006 data_req, data_resp  in  1 each  D-side access start / completion strobes.
REQ-007 l1_req, l1_resp  in  1 each  L1-to-next-level access start / completion strobes.
REQ-008 br_resolve, br_mispredict  in  1 each  branch resolved / resolved-and-mispredicted strobes.
REQ-009 mmio_addr  in  32  byte address from the MEM stage.
REQ-010 mmio_read, mmio_write  in  1 each  MEM-stage load / store strobes.
REQ-011 mmio_wdata  in  CTR_WIDTH  store data.
REQ-012 mmio_rdata  out  CTR_WIDTH  registered read data.
REQ-013 mmio_resp  out  1  one-cycle read/write acknowledge.
REQ-014 frozen  out  1  counters currently frozen.

Function
REQ-015 Counter map by mmio_addr[4:2]: 0 instr accesses, 1 data accesses, 2 l1 accesses, 3 instr cycles, 4 data cycles, 5 l1 cycles, 6 predictions, 7 mispredictions.
REQ-016 Access hit only when mmio_addr < MMIO_LIMIT; at or above it, reads/writes are ignored, mmio_resp stays 0, and no counter changes.
REQ-017 Per port (instr, data, l1), a 2-state FSM IDLE/BUSY: IDLE->BUSY on req without resp; BUSY->IDLE on resp; req in BUSY is ignored.
REQ-018 Cycle counter of a port increments once for every cycle the port is BUSY, plus once for an IDLE cycle with req asserted.
REQ-019 Access counter of a port increments once on each resp accepted: in BUSY, or in IDLE together with req (single-cycle access, FSM stays IDLE).
REQ-020 resp in IDLE without req is ignored.
REQ-021 Predictions counter increments on br_resolve; mispredictions increments on br_resolve AND br_mispredict; br_mispredict alone is ignored.
REQ-022 All counters saturate at all-ones; no wrap.
REQ-023 Hit read: mmio_resp=1 and mmio_rdata=selected counter value sampled in the request cycle, both on the next cycle; mmio_rdata holds its value otherwise.
REQ-024 Hit write, one cycle after: mmio_resp=1. Effects at the request edge: wdata[31]=1 clears all 8 counters; otherwise the addressed counter is cleared.
REQ-025 Hit write: wdata[30]=1 sets frozen; wdata[29]=1 clears frozen; both set: frozen unchanged.
REQ-026 While frozen=1, no counter increments; FSMs keep tracking; clears still apply.
REQ-027 Clear and increment of the same counter in the same cycle: clear wins, result 0.
REQ-028 Simultaneous hit read and write: write effects apply; the read returns the pre-write value; mmio_resp=1 for one cycle.
REQ-029 Back-to-back hit accesses on consecutive cycles each produce a one-cycle mmio_resp.

Reset
REQ-030 rst_n=0 immediately forces all counters=0, all FSMs=IDLE, frozen=0, mmio_resp=0, and mmio_rdata=0, independent of clk.
REQ-031 Reset mid-access abandons the access: a later resp without req is ignored per REQ-020.
REQ-032 First counting edge is the first rising clk edge after rst_n deasserts.

Verification
REQ-033 instr_req at cycle 0, instr_resp at cycle 3 -> instr cycles=4, instr accesses=1, and FSM IDLE at cycle 4.
REQ-034 data_req and data_resp together for 1 cycle -> data cycles=1, data accesses=1, FSM IDLE; a later lone data_resp -> no change.
REQ-035 5 br_resolve pulses, 2 with br_mispredict, then read addr 0x18 and 0x1C -> rdata 5 then 2, each one cycle after its request with mmio_resp=1.
REQ-036 Write 0x40000000 to addr 0 -> frozen=1; 10 busy l1 cycles -> l1 cycles unchanged; write 0x20000000 -> frozen=0, counting resumes.
REQ-037 Counter preloaded near all-ones by events -> holds 0xFFFFFFFF; write 0x0 to its address in the same cycle as an event -> 0.
REQ-038 Read at addr 0x20 and write at 0x100 -> mmio_resp stays 0 and counters unchanged; rst_n pulsed low between clk edges -> all outputs 0 immediately.

Source files
------------

// File: rtl/perf_counter_if.sv
// MMIO bus between the MEM stage and the performance counter block.
// The MEM stage drives the request fields and the counter block returns registered read data and the acknowledge.
interface perf_counter_if #(
    parameter int CTR_WIDTH = 32
);
    logic [31:0]          mmio_addr;
    logic                 mmio_read;
    logic                 mmio_write;
    logic [CTR_WIDTH-1:0] mmio_wdata;
    logic [CTR_WIDTH-1:0] mmio_rdata;
    logic                 mmio_resp;

    modport master (
        output mmio_addr, mmio_read, mmio_write, mmio_wdata,
        input  mmio_rdata, mmio_resp
    );

    modport slave (
        input  mmio_addr, mmio_read, mmio_write, mmio_wdata,
        output mmio_rdata, mmio_resp
    );
endinterface

// File: rtl/perf_counter_ctrl.sv
// Eight saturating performance counters that track access counts and busy cycles for three memory ports, plus branch prediction statistics.
// The counters are read, cleared and frozen through a small MMIO window.
module perf_counter_ctrl #(
    parameter int CTR_WIDTH  = 32,
    parameter int MMIO_LIMIT = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_req,
    input  logic             instr_resp,
    input  logic             data_req,
    input  logic             data_resp,
    input  logic             l1_req,
    input  logic             l1_resp,
    input  logic             br_resolve,
    input  logic             br_mispredict,
    perf_counter_if.slave    bus,
    output logic             frozen
);
    localparam int NUM_CTR  = 8;
    localparam int NUM_PORT = 3;

    typedef logic [CTR_WIDTH-1:0] ctr_t;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} port_state_e;

    function automatic ctr_t sat_inc(input ctr_t value);
        return (value == {CTR_WIDTH{1'b1}}) ? value : value + ctr_t'(1);
    endfunction

    port_state_e         state_r [NUM_PORT];
    ctr_t                ctr_r   [NUM_CTR];
    ctr_t                rdata_r;
    logic                resp_r;
    logic                frozen_r;

    logic [NUM_PORT-1:0] req_s;
    logic [NUM_PORT-1:0] resp_s;
    logic [NUM_PORT-1:0] busy_s;
    logic [NUM_CTR-1:0]  ev_s;
    logic [NUM_CTR-1:0]  inc_s;
    logic [NUM_CTR-1:0]  clr_s;
    logic                hit_s;
    logic                rd_hit_s;
    logic                wr_hit_s;
    logic [2:0]          sel_s;
    logic [2:0]          ctl_s;
    logic                frozen_nxt_s;

    assign req_s    = {l1_req,  data_req,  instr_req};
    assign resp_s   = {l1_resp, data_resp, instr_resp};
    assign hit_s    = (bus.mmio_addr < 32'(MMIO_LIMIT));
    assign rd_hit_s = hit_s & bus.mmio_read;
    assign wr_hit_s = hit_s & bus.mmio_write;
    assign sel_s    = bus.mmio_addr[4:2];
    // Store-data bits 31..29 are clear-all / freeze / unfreeze; narrower builds zero-extend.
    assign ctl_s    = 3'(32'(bus.mmio_wdata) >> 29);

    // Decode which ports are mid-access.
    always_comb begin
        busy_s = '0;
        for (int p = 0; p < NUM_PORT; p++) begin
            busy_s[p] = (state_r[p] == ST_BUSY);
        end
    end

    // Raw events, gated by freeze, and clear requests from MMIO stores.
    always_comb begin
        ev_s      = '0;
        ev_s[2:0] = resp_s & (busy_s | req_s);
        ev_s[5:3] = busy_s | req_s;
        ev_s[6]   = br_resolve;
        ev_s[7]   = br_resolve & br_mispredict;
        if (frozen_r) begin
            inc_s = '0;
        end else begin
            inc_s = ev_s;
        end
        clr_s = '0;
        if (wr_hit_s) begin
            if (ctl_s[2]) begin
                clr_s = '1;
            end else begin
                clr_s[sel_s] = 1'b1;
            end
        end else begin
            clr_s = '0;
        end
        if (wr_hit_s && ctl_s[1] && !ctl_s[0]) begin
            frozen_nxt_s = 1'b1;
        end else if (wr_hit_s && ctl_s[0] && !ctl_s[1]) begin
            frozen_nxt_s = 1'b0;
        end else begin
            frozen_nxt_s = frozen_r;
        end
    end

    // Per-port access tracker; a request seen while busy is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORT; p++) begin
                state_r[p] <= ST_IDLE;
            end
        end else begin
            for (int p = 0; p < NUM_PORT; p++) begin
                case (state_r[p])
                    ST_IDLE: state_r[p] <= (req_s[p] && !resp_s[p]) ? ST_BUSY : ST_IDLE;
                    ST_BUSY: state_r[p] <= resp_s[p] ? ST_IDLE : ST_BUSY;
                    default: state_r[p] <= ST_IDLE;
                endcase
            end
        end
    end

    // Counter bank: clear beats increment, increments saturate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CTR; i++) begin
                ctr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CTR; i++) begin
                if (clr_s[i]) begin
                    ctr_r[i] <= '0;
                end else if (inc_s[i]) begin
                    ctr_r[i] <= sat_inc(ctr_r[i]);
                end else begin
                    ctr_r[i] <= ctr_r[i];
                end
            end
        end
    end

    // MMIO response path; read data reflects the counter value before any same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r  <= '0;
            resp_r   <= 1'b0;
            frozen_r <= 1'b0;
        end else begin
            resp_r   <= rd_hit_s | wr_hit_s;
            frozen_r <= frozen_nxt_s;
            if (rd_hit_s) begin
                rdata_r <= ctr_r[sel_s];
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.mmio_rdata = rdata_r;
    assign bus.mmio_resp  = resp_r;
    assign frozen         = frozen_r;
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Directed bench for perf_counter_ctrl: a 32-bit instance for the functional scenarios
// and an 8-bit instance for reaching saturation in a short run.
module tb_perf_counter_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic instr_req, instr_resp, data_req, data_resp, l1_req, l1_resp;
    logic br_resolve, br_mispredict, frozen;
    logic l1_req2, l1_resp2, frozen2;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    perf_counter_if #(.CTR_WIDTH(32)) bus ();
    perf_counter_if #(.CTR_WIDTH(8))  bus2 ();

    perf_counter_ctrl #(.CTR_WIDTH(32), .MMIO_LIMIT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req(instr_req), .instr_resp(instr_resp),
        .data_req(data_req), .data_resp(data_resp),
        .l1_req(l1_req), .l1_resp(l1_resp),
        .br_resolve(br_resolve), .br_mispredict(br_mispredict),
        .bus(bus), .frozen(frozen)
    );

    perf_counter_ctrl #(.CTR_WIDTH(8), .MMIO_LIMIT(32)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .instr_req(1'b0), .instr_resp(1'b0),
        .data_req(1'b0), .data_resp(1'b0),
        .l1_req(l1_req2), .l1_resp(l1_resp2),
        .br_resolve(1'b0), .br_mispredict(1'b0),
        .bus(bus2), .frozen(frozen2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus.mmio_addr = addr;
        bus.mmio_read = 1'b1;
        tick();
        bus.mmio_read = 1'b0;
        check({tag, " resp"}, 32'(bus.mmio_resp), 32'd1);
        check({tag, " rdata"}, bus.mmio_rdata, exp);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input string tag);
        bus.mmio_addr  = addr;
        bus.mmio_wdata = data;
        bus.mmio_write = 1'b1;
        tick();
        bus.mmio_write = 1'b0;
        check({tag, " resp"}, 32'(bus.mmio_resp), 32'd1);
    endtask

    task automatic rd2(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus2.mmio_addr = addr;
        bus2.mmio_read = 1'b1;
        tick();
        bus2.mmio_read = 1'b0;
        check({tag, " resp"}, 32'(bus2.mmio_resp), 32'd1);
        check({tag, " rdata"}, 32'(bus2.mmio_rdata), exp);
    endtask

    initial begin
        rst_n = 1'b0;
        {instr_req, instr_resp, data_req, data_resp, l1_req, l1_resp} = 6'b0;
        {br_resolve, br_mispredict, l1_req2, l1_resp2} = 4'b0;
        bus.mmio_addr = 32'h0;  bus.mmio_read = 1'b0;  bus.mmio_write = 1'b0;  bus.mmio_wdata = 32'h0;
        bus2.mmio_addr = 32'h0; bus2.mmio_read = 1'b0; bus2.mmio_write = 1'b0; bus2.mmio_wdata = 8'h0;
        #1;
        check("reset resp", 32'(bus.mmio_resp), 32'd0);
        check("reset rdata", bus.mmio_rdata, 32'h0);
        check("reset frozen", 32'(frozen), 32'd0);
        #2 rst_n = 1'b1;
        tick();

        // Four-cycle instruction access
        instr_req = 1'b1; tick(); instr_req = 1'b0;
        tick(); tick();
        instr_resp = 1'b1; tick(); instr_resp = 1'b0;
        rd(32'h0C, 32'd4, "instr cycles");
        rd(32'h00, 32'd1, "instr accesses");
        instr_resp = 1'b1; tick(); instr_resp = 1'b0;
        rd(32'h00, 32'd1, "instr lone resp acc");
        rd(32'h0C, 32'd4, "instr lone resp cyc");

        // Single-cycle data access, then a stray response
        data_req = 1'b1; data_resp = 1'b1; tick(); data_req = 1'b0; data_resp = 1'b0;
        rd(32'h10, 32'd1, "data cycles");
        rd(32'h04, 32'd1, "data accesses");
        data_resp = 1'b1; tick(); data_resp = 1'b0;
        rd(32'h04, 32'd1, "data lone resp acc");
        rd(32'h10, 32'd1, "data lone resp cyc");

        // Branch statistics; back-to-back reads
        for (int i = 0; i < 5; i++) begin
            br_resolve = 1'b1; br_mispredict = (i < 2); tick();
        end
        br_resolve = 1'b0; br_mispredict = 1'b1; tick(); br_mispredict = 1'b0;
        rd(32'h18, 32'd5, "predictions");
        rd(32'h1C, 32'd2, "mispredictions");
        tick();
        check("resp one cycle", 32'(bus.mmio_resp), 32'd0);

        // Freeze while l1 is busy, then resume
        wr(32'h00, 32'h4000_0000, "freeze wr");
        check("frozen set", 32'(frozen), 32'd1);
        l1_req = 1'b1; tick(); l1_req = 1'b0;
        repeat (9) tick();
        rd(32'h14, 32'd0, "l1 cycles frozen");
        rd(32'h08, 32'd0, "l1 accesses frozen");
        wr(32'h00, 32'h2000_0000, "unfreeze wr");
        check("frozen clear", 32'(frozen), 32'd0);
        tick(); tick();
        l1_resp = 1'b1; tick(); l1_resp = 1'b0;
        rd(32'h14, 32'd3, "l1 cycles resumed");
        rd(32'h08, 32'd1, "l1 accesses resumed");
        rd(32'h00, 32'd0, "addressed clear");
        rd(32'h0C, 32'd4, "other ctr kept");

        // Freeze bits both set leave the state alone
        wr(32'h0C, 32'h4000_0000, "freeze2 wr");
        wr(32'h0C, 32'h6000_0000, "both bits wr");
        check("both bits frozen", 32'(frozen), 32'd1);
        wr(32'h0C, 32'h2000_0000, "unfreeze2 wr");
        check("unfrozen again", 32'(frozen), 32'd0);
        rd(32'h0C, 32'd0, "instr cycles cleared");

        // Clear-all
        wr(32'h04, 32'h8000_0000, "clear all wr");
        rd(32'h18, 32'd0, "clear all pred");
        rd(32'h14, 32'd0, "clear all l1 cyc");
        rd(32'h10, 32'd0, "clear all data cyc");

        // Simultaneous read and write returns the pre-write value
        repeat (3) begin br_resolve = 1'b1; tick(); end
        br_resolve = 1'b0;
        bus.mmio_addr = 32'h18; bus.mmio_wdata = 32'h0;
        bus.mmio_read = 1'b1; bus.mmio_write = 1'b1; tick();
        bus.mmio_read = 1'b0; bus.mmio_write = 1'b0;
        check("rdwr resp", 32'(bus.mmio_resp), 32'd1);
        check("rdwr rdata", bus.mmio_rdata, 32'd3);
        tick();
        check("rdwr resp drop", 32'(bus.mmio_resp), 32'd0);
        rd(32'h18, 32'd0, "rdwr cleared");

        // Out-of-window accesses
        repeat (2) begin br_resolve = 1'b1; tick(); end
        br_resolve = 1'b0;
        rd(32'h18, 32'd2, "pre miss pred");
        bus.mmio_addr = 32'h20; bus.mmio_read = 1'b1; tick(); bus.mmio_read = 1'b0;
        check("miss rd resp", 32'(bus.mmio_resp), 32'd0);
        check("miss rd hold", bus.mmio_rdata, 32'd2);
        bus.mmio_addr = 32'h100; bus.mmio_wdata = 32'hC000_0000;
        bus.mmio_write = 1'b1; tick(); bus.mmio_write = 1'b0;
        check("miss wr resp", 32'(bus.mmio_resp), 32'd0);
        check("miss wr frozen", 32'(frozen), 32'd0);
        rd(32'h18, 32'd2, "miss wr no clear");

        // Saturation on the narrow instance, then clear racing an increment
        l1_req2 = 1'b1; tick(); l1_req2 = 1'b0;
        repeat (299) tick();
        rd2(32'h14, 32'hFF, "sat l1 cycles");
        bus2.mmio_addr = 32'h14; bus2.mmio_wdata = 8'h00; bus2.mmio_write = 1'b1;
        l1_resp2 = 1'b1; tick();
        bus2.mmio_write = 1'b0; l1_resp2 = 1'b0;
        check("sat clr resp", 32'(bus2.mmio_resp), 32'd1);
        rd2(32'h14, 32'd0, "clear beats inc");
        rd2(32'h08, 32'd1, "sat l1 accesses");

        // Asynchronous reset mid-access
        wr(32'h00, 32'h4000_0000, "pre reset freeze");
        instr_req = 1'b1; tick(); instr_req = 1'b0;
        rd(32'h18, 32'd2, "pre reset rd");
        #2 rst_n = 1'b0;
        #1;
        check("async rst resp", 32'(bus.mmio_resp), 32'd0);
        check("async rst rdata", bus.mmio_rdata, 32'h0);
        check("async rst frozen", 32'(frozen), 32'd0);
        check("async rst rdata2", 32'(bus2.mmio_rdata), 32'h0);
        #2 rst_n = 1'b1;
        instr_resp = 1'b1; tick(); instr_resp = 1'b0;
        rd(32'h00, 32'd0, "post rst lone resp");
        rd(32'h0C, 32'd0, "post rst instr cyc");
        rd(32'h18, 32'd0, "post rst pred");
        instr_req = 1'b1; instr_resp = 1'b1; tick(); instr_req = 1'b0; instr_resp = 1'b0;
        rd(32'h0C, 32'd1, "post rst counting");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
